// File: rtl/ctrl_pipe.sv
// Control pipeline ID->EX->MEM->WB with write-address select, load-use stall
// detection and EX-stage forwarding selects.
module ctrl_pipe #(
    parameter int unsigned RA_W     = 5,
    parameter int unsigned LINK_REG = 31
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            branch_d,
    input  logic            jump_d,
    input  logic            reg_dst_d,
    input  logic            we_reg_d,
    input  logic            alu_src_d,
    input  logic            we_dm_d,
    input  logic            dm2reg_d,
    input  logic [1:0]      alu_op_d,
    input  logic [RA_W-1:0] rs_d,
    input  logic [RA_W-1:0] rt_d,
    input  logic [RA_W-1:0] rd_d,
    input  logic            flush_e,
    output logic            alu_src_e,
    output logic [1:0]      alu_op_e,
    output logic [RA_W-1:0] rs_e,
    output logic [RA_W-1:0] rt_e,
    output logic [RA_W-1:0] wa_e,
    output logic            we_dm_m,
    output logic            we_reg_m,
    output logic [RA_W-1:0] wa_m,
    output logic            we_reg_w,
    output logic            dm2reg_w,
    output logic [RA_W-1:0] wa_w,
    output logic            stall_f,
    output logic            stall_d,
    output logic [1:0]      fwd_a_e,
    output logic [1:0]      fwd_b_e
);

    logic [RA_W-1:0] wa_d;
    logic            we_reg_e;
    logic            we_dm_e;
    logic            dm2reg_e;
    logic            dm2reg_m;
    logic            lu_stall;
    logic            bubble;

    // Branch redirect is resolved in ID, so branch_d never enters the pipe.
    logic unused_branch;
    assign unused_branch = branch_d;

    always_comb begin
        if (jump_d && we_reg_d) begin
            wa_d = RA_W'(LINK_REG);
        end else if (reg_dst_d) begin
            wa_d = rd_d;
        end else begin
            wa_d = rt_d;
        end
    end

    assign lu_stall = dm2reg_e && (wa_e != '0) && ((wa_e == rs_d) || (wa_e == rt_d));
    assign bubble   = flush_e || lu_stall;
    assign stall_f  = lu_stall;
    assign stall_d  = lu_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_src_e <= 1'b0;
            alu_op_e  <= 2'b00;
            rs_e      <= '0;
            rt_e      <= '0;
            wa_e      <= '0;
            we_reg_e  <= 1'b0;
            we_dm_e   <= 1'b0;
            dm2reg_e  <= 1'b0;
            we_reg_m  <= 1'b0;
            we_dm_m   <= 1'b0;
            dm2reg_m  <= 1'b0;
            wa_m      <= '0;
            we_reg_w  <= 1'b0;
            dm2reg_w  <= 1'b0;
            wa_w      <= '0;
        end else begin
            if (bubble) begin
                alu_src_e <= 1'b0;
                alu_op_e  <= 2'b00;
                rs_e      <= '0;
                rt_e      <= '0;
                wa_e      <= '0;
                we_reg_e  <= 1'b0;
                we_dm_e   <= 1'b0;
                dm2reg_e  <= 1'b0;
            end else begin
                alu_src_e <= alu_src_d;
                alu_op_e  <= alu_op_d;
                rs_e      <= rs_d;
                rt_e      <= rt_d;
                wa_e      <= wa_d;
                we_reg_e  <= we_reg_d;
                we_dm_e   <= we_dm_d;
                dm2reg_e  <= dm2reg_d;
            end
            // MEM and WB never stall.
            we_reg_m <= we_reg_e;
            we_dm_m  <= we_dm_e;
            dm2reg_m <= dm2reg_e;
            wa_m     <= wa_e;
            we_reg_w <= we_reg_m;
            dm2reg_w <= dm2reg_m;
            wa_w     <= wa_m;
        end
    end

    // MEM overrides WB when both stages target the same register.
    always_comb begin
        fwd_a_e = 2'b00;
        if (we_reg_w && (wa_w != '0) && (wa_w == rs_e)) fwd_a_e = 2'b01;
        if (we_reg_m && (wa_m != '0) && (wa_m == rs_e)) fwd_a_e = 2'b10;
        fwd_b_e = 2'b00;
        if (we_reg_w && (wa_w != '0) && (wa_w == rt_e)) fwd_b_e = 2'b01;
        if (we_reg_m && (wa_m != '0) && (wa_m == rt_e)) fwd_b_e = 2'b10;
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: reset, forwarding, load-use, $0, JAL and flush.
module tb_ctrl_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       branch_d, jump_d, reg_dst_d, we_reg_d, alu_src_d, we_dm_d, dm2reg_d;
    logic [1:0] alu_op_d;
    logic [4:0] rs_d, rt_d, rd_d;
    logic       flush_e;
    logic       alu_src_e;
    logic [1:0] alu_op_e;
    logic [4:0] rs_e, rt_e, wa_e;
    logic       we_dm_m, we_reg_m;
    logic [4:0] wa_m;
    logic       we_reg_w, dm2reg_w;
    logic [4:0] wa_w;
    logic       stall_f, stall_d;
    logic [1:0] fwd_a_e, fwd_b_e;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ctrl_pipe #(.RA_W(5), .LINK_REG(31)) dut (
        .clk(clk), .rst(rst),
        .branch_d(branch_d), .jump_d(jump_d), .reg_dst_d(reg_dst_d), .we_reg_d(we_reg_d),
        .alu_src_d(alu_src_d), .we_dm_d(we_dm_d), .dm2reg_d(dm2reg_d), .alu_op_d(alu_op_d),
        .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .flush_e(flush_e),
        .alu_src_e(alu_src_e), .alu_op_e(alu_op_e), .rs_e(rs_e), .rt_e(rt_e), .wa_e(wa_e),
        .we_dm_m(we_dm_m), .we_reg_m(we_reg_m), .wa_m(wa_m),
        .we_reg_w(we_reg_w), .dm2reg_w(dm2reg_w), .wa_w(wa_w),
        .stall_f(stall_f), .stall_d(stall_d), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic jp, input logic rdst, input logic we, input logic asrc,
                          input logic wdm, input logic d2r, input logic [1:0] op,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        branch_d = 1'b0; jump_d = jp; reg_dst_d = rdst; we_reg_d = we; alu_src_d = asrc;
        we_dm_d = wdm; dm2reg_d = d2r; alu_op_d = op; rs_d = rs; rt_d = rt; rd_d = rd;
    endtask

    task automatic set_nop();
        set_id(0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0);
        flush_e = 1'b0;
    endtask

    task automatic do_reset();
        set_nop();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_nop();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({alu_src_e, alu_op_e, rs_e, rt_e, wa_e} !== 18'd0) begin
            failures++;
            $display("FAIL reset_ex got=%h want=0", {alu_src_e, alu_op_e, rs_e, rt_e, wa_e});
        end
        // Mid-stream: random traffic then a one-cycle reset with random inputs still applied.
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_id(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
            flush_e = 1'($urandom);
            tick();
        end
        set_id(1, 1, 1, 1, 1, 1, 2'b11, 5'd7, 5'd8, 5'd9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({alu_src_e, alu_op_e, rs_e, rt_e, wa_e} !== 18'd0) begin
            failures++;
            $display("FAIL midreset_ex got=%h want=0", {alu_src_e, alu_op_e, rs_e, rt_e, wa_e});
        end
        checks++;
        if ({we_dm_m, we_reg_m, wa_m, we_reg_w, dm2reg_w, wa_w} !== 14'd0) begin
            failures++;
            $display("FAIL midreset_mw got=%h want=0",
                     {we_dm_m, we_reg_m, wa_m, we_reg_w, dm2reg_w, wa_w});
        end
        checks++;
        if ({fwd_a_e, fwd_b_e} !== 4'b0000) begin
            failures++;
            $display("FAIL midreset_fwd got=%b want=0000", {fwd_a_e, fwd_b_e});
        end
    endtask

    task automatic test_rtype_chain();
        do_reset();
        set_id(0, 1, 1, 0, 0, 0, 2'b10, 5'd1, 5'd2, 5'd3);   // add $3,$1,$2
        tick();
        checks++;
        if (wa_e !== 5'd3 || alu_op_e !== 2'b10) begin
            failures++;
            $display("FAIL rtype_ex wa_e=%0d alu_op_e=%b want 3/10", wa_e, alu_op_e);
        end
        set_id(0, 1, 1, 0, 0, 0, 2'b10, 5'd3, 5'd4, 5'd6);   // add $6,$3,$4
        #1;
        checks++;
        if (stall_f !== 1'b0) begin
            failures++;
            $display("FAIL rtype_nostall got=%b want=0", stall_f);
        end
        tick();
        checks++;
        if (fwd_a_e !== 2'b10 || fwd_b_e !== 2'b00) begin
            failures++;
            $display("FAIL rtype_fwd_mem a=%b b=%b want 10/00", fwd_a_e, fwd_b_e);
        end
        set_id(0, 1, 1, 0, 0, 0, 2'b10, 5'd1, 5'd2, 5'd7);   // add $7
        tick();
        set_nop();
        tick();
        set_id(0, 1, 1, 0, 0, 0, 2'b10, 5'd7, 5'd0, 5'd10);  // add rs=$7 two apart
        #1;
        checks++;
        if (stall_d !== 1'b0) begin
            failures++;
            $display("FAIL rtype2_nostall got=%b want=0", stall_d);
        end
        tick();
        checks++;
        if (fwd_a_e !== 2'b01 || fwd_b_e !== 2'b00) begin
            failures++;
            $display("FAIL rtype_fwd_wb a=%b b=%b want 01/00", fwd_a_e, fwd_b_e);
        end
        // Both MEM and WB write $9: MEM wins.
        set_id(0, 1, 1, 0, 0, 0, 2'b10, 5'd1, 5'd2, 5'd9);
        tick();
        tick();
        set_id(0, 1, 1, 0, 0, 0, 2'b10, 5'd1, 5'd9, 5'd11);
        tick();
        checks++;
        if (fwd_b_e !== 2'b10 || fwd_a_e !== 2'b00) begin
            failures++;
            $display("FAIL fwd_priority a=%b b=%b want 00/10", fwd_a_e, fwd_b_e);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(0, 0, 1, 1, 0, 1, 2'b00, 5'd1, 5'd5, 5'd12); // lw $5
        tick();
        checks++;
        if (wa_e !== 5'd5) begin
            failures++;
            $display("FAIL lw_wa_e got=%0d want=5", wa_e);
        end
        set_id(0, 1, 1, 0, 0, 0, 2'b10, 5'd5, 5'd2, 5'd8);  // add $8,$5,$2
        #1;
        checks++;
        if (stall_f !== 1'b1 || stall_d !== 1'b1) begin
            failures++;
            $display("FAIL lu_stall f=%b d=%b want 1/1", stall_f, stall_d);
        end
        tick();
        checks++;
        if ({rs_e, rt_e, wa_e, alu_op_e} !== 17'd0 || stall_f !== 1'b0) begin
            failures++;
            $display("FAIL lu_bubble rs=%0d wa=%0d stall=%b want 0/0/0", rs_e, wa_e, stall_f);
        end
        tick();
        checks++;
        if (fwd_a_e !== 2'b01 || we_reg_m !== 1'b0 || rs_e !== 5'd5) begin
            failures++;
            $display("FAIL lu_fwd fwd_a=%b we_reg_m=%b rs_e=%0d want 01/0/5",
                     fwd_a_e, we_reg_m, rs_e);
        end
        checks++;
        if (dm2reg_w !== 1'b1 || wa_w !== 5'd5 || we_reg_w !== 1'b1) begin
            failures++;
            $display("FAIL lu_wb dm2reg_w=%b wa_w=%0d we_reg_w=%b want 1/5/1",
                     dm2reg_w, wa_w, we_reg_w);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        set_id(0, 0, 1, 1, 0, 1, 2'b00, 5'd1, 5'd0, 5'd0);  // lw $0
        tick();
        set_id(0, 1, 1, 0, 0, 0, 2'b10, 5'd0, 5'd0, 5'd0);  // add $0,$0,$0
        #1;
        checks++;
        if (stall_f !== 1'b0) begin
            failures++;
            $display("FAIL zero_nostall got=%b want=0", stall_f);
        end
        tick();
        set_id(0, 1, 1, 0, 0, 0, 2'b10, 5'd0, 5'd0, 5'd4);
        tick();
        checks++;
        if (we_reg_m !== 1'b1 || fwd_a_e !== 2'b00 || fwd_b_e !== 2'b00) begin
            failures++;
            $display("FAIL zero_fwd we_reg_m=%b a=%b b=%b want 1/00/00",
                     we_reg_m, fwd_a_e, fwd_b_e);
        end
    endtask

    task automatic test_jal();
        do_reset();
        set_id(1, 0, 1, 0, 0, 0, 2'b00, 5'd2, 5'd4, 5'd9);
        branch_d = 1'b1;
        tick();
        checks++;
        if (wa_e !== 5'd31) begin
            failures++;
            $display("FAIL jal_wa_e got=%0d want=31", wa_e);
        end
        set_nop();
        tick();
        tick();
        checks++;
        if (we_reg_w !== 1'b1 || wa_w !== 5'd31) begin
            failures++;
            $display("FAIL jal_wb we_reg_w=%b wa_w=%0d want 1/31", we_reg_w, wa_w);
        end
    endtask

    task automatic test_flush();
        do_reset();
        set_id(0, 0, 0, 1, 1, 0, 2'b00, 5'd2, 5'd6, 5'd0);  // sw, no flush
        tick();
        set_nop();
        tick();
        checks++;
        if (we_dm_m !== 1'b1) begin
            failures++;
            $display("FAIL sw_mem got=%b want=1", we_dm_m);
        end
        set_id(0, 0, 0, 1, 1, 0, 2'b00, 5'd2, 5'd6, 5'd0);  // sw, flushed
        flush_e = 1'b1;
        tick();
        checks++;
        if (rs_e !== 5'd0 || alu_src_e !== 1'b0) begin
            failures++;
            $display("FAIL flush_ex rs_e=%0d alu_src_e=%b want 0/0", rs_e, alu_src_e);
        end
        set_nop();
        tick();
        checks++;
        if (we_dm_m !== 1'b0) begin
            failures++;
            $display("FAIL flush_mem got=%b want=0", we_dm_m);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_id(0, 0, 1, 1, 0, 1, 2'b00, 5'd1, 5'd5, 5'd0);  // lw $5
        tick();
        set_id(0, 1, 1, 0, 0, 0, 2'b10, 5'd3, 5'd5, 5'd8);  // uses $5 via rt
        flush_e = 1'b1;
        #1;
        checks++;
        if (stall_f !== 1'b1 || stall_d !== 1'b1) begin
            failures++;
            $display("FAIL flush_lu_stall f=%b d=%b want 1/1", stall_f, stall_d);
        end
        tick();
        flush_e = 1'b0;
        #1;
        checks++;
        if (rt_e !== 5'd0 || stall_f !== 1'b0) begin
            failures++;
            $display("FAIL flush_lu_single rt_e=%0d stall=%b want 0/0", rt_e, stall_f);
        end
        tick();
        checks++;
        if (rt_e !== 5'd5 || fwd_b_e !== 2'b01) begin
            failures++;
            $display("FAIL flush_lu_fwd rt_e=%0d fwd_b=%b want 5/01", rt_e, fwd_b_e);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_nop();
        test_reset();
        test_rtype_chain();
        test_load_use();
        test_zero_reg();
        test_jal();
        test_flush();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
